perm_job_sequencer: RTL and testbench

//  Runs 25-bit x 64-line jobs through permutation_func, one job at a time.
//  Per job it: buffers the host's input lines, resets and starts the core,

---
 rtl/perm_job_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_perm_job_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_job_sequencer.sv
`default_nettype none
// =====================================================================
// Module   : perm_job_sequencer
// Purpose  : Buffers one 64-line job, drives a permutation_func core
//            through reset/start/run and collects its writes in a FIFO.
// Revision : 1.0  initial release
// =====================================================================
module perm_job_sequencer #(
    parameter int NWORDS    = 64,
    parameter int OUT_DEPTH = 64,
    parameter int RST_CYC   = 3,
    parameter int TIMEOUT   = 8191
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [24:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        out_valid,
    output logic [24:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        job_done,
    output logic        err_ovf,
    output logic        err_tmo,
    output logic        core_rst,
    output logic        core_start,
    input  logic        core_done,
    input  logic [6:0]  core_cnt,
    output logic [24:0] core_line_in,
    input  logic        core_wr_en,
    input  logic [24:0] core_wr_val
);
    localparam int c_AW = $clog2(NWORDS);
    localparam int c_FW = $clog2(OUT_DEPTH);
    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam int c_CW = $clog2(RST_CYC + 1);
    localparam logic [c_AW-1:0] c_LAST     = c_AW'(NWORDS - 1);
    localparam logic [c_FW:0]   c_FULL     = (c_FW + 1)'(OUT_DEPTH);
    localparam logic [c_CW-1:0] c_CRST_END = c_CW'(RST_CYC - 1);
    localparam logic [c_TW-1:0] c_TMO_END  = c_TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_ZFILL = 3'd1,
        S_CRST  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [c_AW-1:0]   wptr_q, wptr_d;
    logic [c_CW-1:0]   crst_cnt_q, crst_cnt_d;
    logic [c_TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [24:0]       line_buf_q [NWORDS];
    logic [24:0]       fifo_mem_q [OUT_DEPTH];
    logic [c_FW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [c_FW:0]     count_q, count_d;
    logic              wr_en_q, done_q;
    logic              out_valid_q, ld_ready_q, busy_q, job_done_q;
    logic              err_ovf_q, err_tmo_q, core_rst_q, core_start_q;

    logic              w_buf_we;
    logic [24:0]       w_buf_wdata;
    logic              w_set_done, w_set_tmo;
    logic              w_done_rise, w_cap, w_full, w_push, w_pop;
    logic [6:0]        w_line_addr;

    assign w_done_rise = core_done & ~done_q;
    assign w_cap       = (state_q == S_RUN) & core_wr_en & ~wr_en_q;
    assign w_full      = (count_q == c_FULL);
    assign w_push      = w_cap & ~w_full;
    assign w_pop       = out_ready & out_valid_q;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        crst_cnt_d  = '0;
        tmo_cnt_d   = '0;
        w_buf_we    = 1'b0;
        w_buf_wdata = '0;
        w_set_done  = 1'b0;
        w_set_tmo   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    w_buf_we    = 1'b1;
                    w_buf_wdata = ld_data;
                    if (wptr_q == c_LAST) begin
                        state_d = S_CRST;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                        if (ld_last) state_d = S_ZFILL;
                    end
                end
            end
            S_ZFILL: begin
                w_buf_we = 1'b1;
                if (wptr_q == c_LAST) state_d = S_CRST;
                else                  wptr_d  = wptr_q + 1'b1;
            end
            S_CRST: begin
                if (crst_cnt_q == c_CRST_END) state_d    = S_RUN;
                else                          crst_cnt_d = crst_cnt_q + 1'b1;
            end
            S_RUN: begin
                // A done edge in the expiry cycle still counts as success
                if (w_done_rise) begin
                    state_d    = S_DONE;
                    w_set_done = 1'b1;
                end else if (tmo_cnt_q == c_TMO_END) begin
                    state_d   = S_DONE;
                    w_set_tmo = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                wptr_d  = '0;
                state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_LOAD;
            wptr_q       <= '0;
            crst_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            ld_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            job_done_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
            core_rst_q   <= 1'b1;
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            crst_cnt_q   <= crst_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            wr_en_q      <= core_wr_en;
            done_q       <= core_done;
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q      <= count_d;
            out_valid_q  <= (count_d != '0);
            // Status outputs follow the next state so they line up with it
            ld_ready_q   <= (state_d == S_LOAD);
            busy_q       <= (state_d != S_LOAD);
            core_rst_q   <= (state_d != S_RUN);
            core_start_q <= (state_d == S_RUN);
            job_done_q   <= w_set_done;
            if (w_cap && w_full) err_ovf_q <= 1'b1;
            if (w_set_tmo)       err_tmo_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) line_buf_q[wptr_q]   <= w_buf_wdata;
        if (w_push)   fifo_mem_q[wr_ptr_q] <= core_wr_val;
    end

    // Core counts lines from 63 upward; anything past the buffer reads as zero
    assign w_line_addr  = core_cnt - 7'd63;
    assign core_line_in = ({1'b0, w_line_addr} < 8'(NWORDS))
                          ? line_buf_q[w_line_addr[c_AW-1:0]] : '0;

    assign out_data   = fifo_mem_q[rd_ptr_q];
    assign out_valid  = out_valid_q;
    assign ld_ready   = ld_ready_q;
    assign busy       = busy_q;
    assign job_done   = job_done_q;
    assign err_ovf    = err_ovf_q;
    assign err_tmo    = err_tmo_q;
    assign core_rst   = core_rst_q;
    assign core_start = core_start_q;

endmodule
`default_nettype wire

// File: tb/tb_perm_job_sequencer.sv
`default_nettype none
// =====================================================================
// Module   : tb_perm_job_sequencer
// Purpose  : Directed self-checking bench for perm_job_sequencer.
// Revision : 1.0  initial release
// =====================================================================
module tb_perm_job_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_valid = 1'b0;
    logic [24:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        out_valid;
    logic [24:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy, job_done, err_ovf, err_tmo, core_rst, core_start;
    logic        core_done = 1'b0;
    logic [6:0]  core_cnt = '0;
    logic [24:0] core_line_in;
    logic        core_wr_en = 1'b0;
    logic [24:0] core_wr_val = '0;

    int n_checks = 0;
    int n_err    = 0;
    int jd_cnt   = 0;
    logic [24:0] exp_q [$];

    typedef struct {
        int          job;
        logic [6:0]  cnt;
        logic [24:0] exp;
    } vec_t;
    vec_t vec [13];

    perm_job_sequencer dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .job_done(job_done), .err_ovf(err_ovf), .err_tmo(err_tmo),
        .core_rst(core_rst), .core_start(core_start), .core_done(core_done),
        .core_cnt(core_cnt), .core_line_in(core_line_in),
        .core_wr_en(core_wr_en), .core_wr_val(core_wr_val)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (job_done === 1'b1) jd_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load_line(input logic [24:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_start(input string nm, input int exp_n);
        int n;
        n = 0;
        while (core_start !== 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk({nm, "_prestart_cycles"}, n, exp_n);
        chk({nm, "_core_rst_low"}, core_rst, 1'b0);
    endtask

    task automatic core_write(input logic [24:0] d, input bit stored);
        core_wr_en  = 1'b1;
        core_wr_val = d;
        step();
        core_wr_en  = 1'b0;
        step();
        if (stored) exp_q.push_back(d);
    endtask

    task automatic finish_job(input string nm);
        core_done = 1'b1;
        step();
        chk({nm, "_job_done"}, job_done, 1'b1);
        chk({nm, "_start_off"}, core_start, 1'b0);
        core_done = 1'b0;
        step();
        chk({nm, "_job_done_off"}, job_done, 1'b0);
        chk({nm, "_back_to_load"}, ld_ready, 1'b1);
    endtask

    task automatic drain(input string nm);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            chk({nm, "_valid"}, out_valid, 1'b1);
            chk({nm, "_data"}, out_data, exp_q.pop_front());
            step();
        end
        out_ready = 1'b0;
        chk({nm, "_empty"}, out_valid, 1'b0);
    endtask

    task automatic apply_table(input int job);
        for (int i = 0; i < 13; i++) begin
            if (vec[i].job == job) begin
                core_cnt = vec[i].cnt;
                #1;
                chk($sformatf("line_in_job%0d_cnt%0d", job, vec[i].cnt), core_line_in, vec[i].exp);
                step();
            end
        end
    endtask

    initial begin
        int jd0, m;
        // Job 1 holds lines 0..63; job 2 holds 0..4 then zeros
        vec[0]  = '{job: 1, cnt: 7'd64,  exp: 25'd1};
        vec[1]  = '{job: 1, cnt: 7'd100, exp: 25'd37};
        vec[2]  = '{job: 1, cnt: 7'd126, exp: 25'd63};
        vec[3]  = '{job: 1, cnt: 7'd127, exp: 25'd0};
        vec[4]  = '{job: 1, cnt: 7'd0,   exp: 25'd0};
        vec[5]  = '{job: 1, cnt: 7'd62,  exp: 25'd0};
        vec[6]  = '{job: 1, cnt: 7'd90,  exp: 25'd27};
        vec[7]  = '{job: 2, cnt: 7'd65,  exp: 25'd2};
        vec[8]  = '{job: 2, cnt: 7'd67,  exp: 25'd4};
        vec[9]  = '{job: 2, cnt: 7'd68,  exp: 25'd0};
        vec[10] = '{job: 2, cnt: 7'd70,  exp: 25'd0};
        vec[11] = '{job: 2, cnt: 7'd126, exp: 25'd0};
        vec[12] = '{job: 2, cnt: 7'd66,  exp: 25'd3};

        // Reset state
        step();
        step();
        chk("rst_ld_ready", ld_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_job_done", job_done, 1'b0);
        chk("rst_err_ovf", err_ovf, 1'b0);
        chk("rst_err_tmo", err_tmo, 1'b0);
        rst = 1'b1;
        step();

        // Full 64-line job, no zero fill, 64 captured words
        for (int i = 0; i < 64; i++) load_line(25'(i), 1'b0);
        chk("j1_busy", busy, 1'b1);
        chk("j1_ld_ready_off", ld_ready, 1'b0);
        wait_start("j1", 3);
        apply_table(1);
        for (int i = 0; i < 64; i++) core_write(25'h0A5000 + 25'(i), 1'b1);
        finish_job("j1");
        chk("j1_jd_count", jd_cnt, 1);
        drain("j1");

        // Short job with zero fill; held write enable gives one push
        for (int i = 0; i < 5; i++) load_line(25'(i), i == 4);
        wait_start("j2", 62);
        apply_table(2);
        core_wr_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            core_wr_val = 25'h1000 + 25'(k);
            step();
        end
        core_wr_en = 1'b0;
        step();
        exp_q.push_back(25'h1000);
        core_write(25'h2222, 1'b1);
        finish_job("j2");
        chk("j2_jd_count", jd_cnt, 2);
        drain("j2");

        // Overflow: 65 writes with host stalled
        for (int i = 0; i < 3; i++) load_line(25'h3000 + 25'(i), i == 2);
        wait_start("j3", 64);
        for (int i = 0; i < 65; i++) begin
            core_write(25'h1ABC000 + 25'(i), i < 64);
            if (i == 63) chk("j3_ovf_before", err_ovf, 1'b0);
        end
        chk("j3_ovf_after", err_ovf, 1'b1);
        finish_job("j3");
        drain("j3");

        // Timeout: core never signals done
        jd0 = jd_cnt;
        load_line(25'h77, 1'b1);
        wait_start("j4", 66);
        m = 0;
        while (core_start === 1'b1 && m < 9000) begin
            m++;
            step();
        end
        chk("j4_run_cycles", m, 8191);
        chk("j4_err_tmo", err_tmo, 1'b1);
        chk("j4_ovf_sticky", err_ovf, 1'b1);
        chk("j4_core_rst", core_rst, 1'b1);
        step();
        chk("j4_back_to_load", ld_ready, 1'b1);
        chk("j4_no_job_done", jd_cnt, jd0);

        // Reset in the middle of RUN with a word in the FIFO
        load_line(25'h11, 1'b0);
        load_line(25'h12, 1'b1);
        wait_start("j5", 65);
        core_write(25'h5555, 1'b0);
        chk("j5_fifo_has_word", out_valid, 1'b1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mrst_ld_ready", ld_ready, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_core_start", core_start, 1'b0);
        chk("mrst_core_rst", core_rst, 1'b1);
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_err_ovf", err_ovf, 1'b0);
        chk("mrst_err_tmo", err_tmo, 1'b0);
        step();

        // Two back-to-back jobs, FIFO drained only at the end
        jd0 = jd_cnt;
        for (int i = 0; i < 64; i++) load_line(25'(i * 5), 1'b0);
        wait_start("j6", 3);
        core_cnt = 7'd70;
        #1;
        chk("j6_line_in", core_line_in, 25'd35);
        core_write(25'h600001, 1'b1);
        core_write(25'h600002, 1'b1);
        finish_job("j6");
        load_line(25'h99, 1'b1);
        wait_start("j7", 66);
        core_write(25'h700001, 1'b1);
        core_write(25'h700002, 1'b1);
        finish_job("j7");
        chk("j67_jd_count", jd_cnt - jd0, 2);
        drain("j67");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
